// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: FSM states, ALUOp/pc_src/alu_src_b codes,
// opcode/funct values and the control word driven by the decoder.
package mips_mc_control_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_RTEXE  = 4'd7,
    ST_RTWB   = 4'd8,
    ST_ITEXE  = 4'd9,
    ST_ITWB   = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_JREG   = 4'd13
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic op_is_itype(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  // Logical immediates take a zero-extended operand; arithmetic ones sign-extend.
  function automatic logic op_is_logic_imm(input logic [5:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return op_is_itype(op) ||
           (op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW});
  endfunction

  function automatic logic funct_supported(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_SRA, FN_AND,
                      FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_JR};
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational control-word decode from the registered FSM state plus op_code/funct/zero/mem_ready.
// With MIPS_MEM_HANDSHAKE_EN defined, FETCH only loads IR and advances PC in the mem_ready cycle.
module mips_mc_ctrl_decode
  import mips_mc_control_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic [5:0]        op_code_i,
  input  logic [5:0]        funct_i,
  input  logic              zero_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_e st;
  ctrl_t  c;
  logic   fetch_done;

  assign st = state_e'(state_i);

`ifdef MIPS_MEM_HANDSHAKE_EN
  assign fetch_done = mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign fetch_done       = 1'b1;
`endif

  always_comb begin
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.i_or_d    = 1'b0;
        c.alu_src_a = 1'b0;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
        c.ir_write  = fetch_done;
        c.pc_en     = fetch_done;
      end
      ST_DECODE: begin
        // Branch target is computed speculatively here so BRANCH can use ALUOut.
        c.alu_src_a  = 1'b0;
        c.alu_src_b  = SRCB_BRANCH;
        c.alu_op     = ALUOP_ADD;
        c.illegal_op = ~op_supported(op_code_i);
      end
      ST_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = 1'b0;
      end
      ST_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_RTEXE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_REGB;
        c.alu_op     = ALUOP_FUNCT;
        c.illegal_op = ~funct_supported(funct_i);
      end
      ST_RTWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_ITEXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_IMM;
        c.imm_zext  = op_is_logic_imm(op_code_i);
      end
      ST_ITWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b0;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.pc_en     = (op_code_i == OP_BNE) ? ~zero_i : zero_i;
      end
      ST_JUMP: begin
        c.pc_src = PCSRC_JUMP;
        c.pc_en  = 1'b1;
      end
      ST_JREG: begin
        c.pc_src = PCSRC_REGA;
        c.pc_en  = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and next-state logic only.
// MIPS_MEM_HANDSHAKE_EN defined: FETCH/MEMRD/MEMWR wait for mem_ready; otherwise each lasts one cycle.
module mips_mc_control
  import mips_mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_done;

`ifdef MIPS_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = mem_done ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (op_code == OP_LW || op_code == OP_SW)       state_d = ST_MEMADR;
        else if (op_code == OP_RTYPE)                   state_d = (funct == FN_JR) ? ST_JREG : ST_RTEXE;
        else if (op_is_itype(op_code))                  state_d = ST_ITEXE;
        else if (op_code == OP_BEQ || op_code == OP_BNE) state_d = ST_BRANCH;
        else if (op_code == OP_J)                       state_d = ST_JUMP;
        else                                            state_d = ST_FETCH;
      end
      ST_MEMADR: state_d = (op_code == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = mem_done ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = mem_done ? ST_FETCH : ST_MEMWR;
      ST_RTEXE:  state_d = ST_RTWB;
      ST_ITEXE:  state_d = ST_ITWB;
      ST_MEMWB, ST_RTWB, ST_ITWB, ST_BRANCH, ST_JUMP, ST_JREG: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  mips_mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_code_i   (op_code),
    .funct_i     (funct),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign i_or_d     = ctrl.i_or_d;
  assign ir_write   = ctrl.ir_write;
  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign imm_zext   = ctrl.imm_zext;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-instruction expected control traces built from the instruction
// class, compared cycle by cycle against directed and random instruction streams.
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  logic       clk = 1'b0;
  logic       rstb;
  logic [5:0] op_code, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_en, alu_src_a, imm_zext;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state;
  } obs_t;

  obs_t obs;
  obs_t exp_q[$];

  assign obs = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                imm_zext, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op, state};

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .rstb(rstb), .op_code(op_code), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
  );

  logic [5:0] legal_ops [11] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                 6'h04, 6'h05, 6'h02};
  logic [5:0] legal_fns [11] = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2A, 6'h08};
  logic [5:0] dir_op [13] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h04,
                              6'h04, 6'h05, 6'h05, 6'h02, 6'h3F};
  logic [5:0] dir_fn [13] = '{6'h00, 6'h00, 6'h20, 6'h3F, 6'h08, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic       dir_z  [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic pick_ready();
`ifdef MIPS_MEM_HANDSHAKE_EN
    return 1'b1;
`else
    return 1'($urandom);
`endif
  endfunction

  function automatic obs_t reset_obs();
    obs_t e = '0;
    e.state = ST_RESET;
    return e;
  endfunction

  // Expected cycle-by-cycle controls for one instruction, starting at its FETCH cycle.
  task automatic build_trace(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t e;
    exp_q.delete();
    e = '0; e.state = ST_FETCH; e.mem_req = 1; e.ir_write = 1; e.pc_en = 1; e.alu_src_b = 2'b01;
    exp_q.push_back(e);
    e = '0; e.state = ST_DECODE; e.alu_src_b = 2'b11;
    e.illegal_op = !(op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                                6'h04, 6'h05, 6'h02});
    exp_q.push_back(e);
    case (op)
      6'h23, 6'h2B: begin
        e = '0; e.state = ST_MEMADR; e.alu_src_a = 1; e.alu_src_b = 2'b10; exp_q.push_back(e);
        if (op == 6'h23) begin
          e = '0; e.state = ST_MEMRD; e.mem_req = 1; e.i_or_d = 1; exp_q.push_back(e);
          e = '0; e.state = ST_MEMWB; e.reg_write = 1; e.mem_to_reg = 1; exp_q.push_back(e);
        end else begin
          e = '0; e.state = ST_MEMWR; e.mem_req = 1; e.mem_write = 1; e.i_or_d = 1;
          exp_q.push_back(e);
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          e = '0; e.state = ST_JREG; e.pc_src = 2'b11; e.pc_en = 1; exp_q.push_back(e);
        end else begin
          e = '0; e.state = ST_RTEXE; e.alu_src_a = 1; e.alu_op = 2'b10;
          e.illegal_op = !(fn inside {6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h24, 6'h25,
                                      6'h26, 6'h27, 6'h2A});
          exp_q.push_back(e);
          e = '0; e.state = ST_RTWB; e.reg_write = 1; e.reg_dst = 1; exp_q.push_back(e);
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        e = '0; e.state = ST_ITEXE; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
        e.imm_zext = (op inside {6'h0C, 6'h0D, 6'h0E});
        exp_q.push_back(e);
        e = '0; e.state = ST_ITWB; e.reg_write = 1; exp_q.push_back(e);
      end
      6'h04, 6'h05: begin
        e = '0; e.state = ST_BRANCH; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
        e.pc_en = (op == 6'h04) ? z : !z;
        exp_q.push_back(e);
      end
      6'h02: begin
        e = '0; e.state = ST_JUMP; e.pc_src = 2'b10; e.pc_en = 1; exp_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    obs_t e;
    rstb = 1'b1; op_code = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #1 rstb = 1'b0;
    #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_assert: got %h expected %h", obs, reset_obs());
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_held: got %h expected %h", obs, reset_obs());
    end
    #2 rstb = 1'b1;
    #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", obs, reset_obs());
    end
    @(posedge clk); #1;
    build_trace(6'h00, 6'h20, 1'b0);
    e = exp_q[0];
    n_checks++;
    if (obs !== e) begin
      n_fail++; $display("FAIL reset_to_fetch: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 13; i++) begin
      build_trace(dir_op[i], dir_fn[i], dir_z[i]);
      for (int c = 0; c < exp_q.size(); c++) begin
        op_code   = (c == 0) ? 6'($urandom) : dir_op[i];
        funct     = (c == 0) ? 6'($urandom) : dir_fn[i];
        zero      = dir_z[i];
        mem_ready = pick_ready();
        #1;
        n_checks++;
        if (obs !== exp_q[c]) begin
          n_fail++;
          $display("FAIL directed op=%h fn=%h z=%0b cyc%0d: got %h expected %h",
                   dir_op[i], dir_fn[i], dir_z[i], c + 1, obs, exp_q[c]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic       z;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 13) < 11) ? legal_ops[$urandom_range(0, 10)] : 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 10)];
      z  = 1'($urandom);
      build_trace(op, fn, z);
      for (int c = 0; c < exp_q.size(); c++) begin
        op_code   = (c == 0) ? 6'($urandom) : op;
        funct     = (c == 0) ? 6'($urandom) : fn;
        zero      = z;
        mem_ready = pick_ready();
        #1;
        n_checks++;
        if (obs !== exp_q[c]) begin
          n_fail++;
          $display("FAIL random op=%h fn=%h z=%0b cyc%0d: got %h expected %h",
                   op, fn, z, c + 1, obs, exp_q[c]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t e;
    build_trace(6'h2B, 6'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      op_code = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp_q[c]) begin
        n_fail++; $display("FAIL sw_before_reset cyc%0d: got %h expected %h", c + 1, obs, exp_q[c]);
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    #1 rstb = 1'b0;
    #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_mid_memwr: got %h expected %h", obs, reset_obs());
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_mid_held: got %h expected %h", obs, reset_obs());
    end
    #2 rstb = 1'b1;
    #1;
    n_checks++;
    if (obs !== reset_obs()) begin
      n_fail++; $display("FAIL reset_mid_release: got %h expected %h", obs, reset_obs());
    end
    @(posedge clk); #1;
    build_trace(6'h00, 6'h20, 1'b0);
    e = exp_q[0];
    n_checks++;
    if (obs !== e) begin
      n_fail++; $display("FAIL reset_mid_refetch: got %h expected %h", obs, e);
    end
  endtask

`ifdef MIPS_MEM_HANDSHAKE_EN
  task automatic test_handshake();
    obs_t stall;
    build_trace(6'h23, 6'h00, 1'b0);
    stall = exp_q[0]; stall.ir_write = 1'b0; stall.pc_en = 1'b0;
    op_code = 6'h23; funct = 6'h00; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0; #1;
      n_checks++;
      if (obs !== stall) begin
        n_fail++; $display("FAIL hs_fetch_stall%0d: got %h expected %h", i, obs, stall);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      for (int w = 0; w < ((c == 3) ? 2 : 0); w++) begin
        mem_ready = 1'b0; #1;
        n_checks++;
        if (obs !== exp_q[3]) begin
          n_fail++; $display("FAIL hs_memrd_stall%0d: got %h expected %h", w, obs, exp_q[3]);
        end
        @(posedge clk); #1;
      end
      mem_ready = 1'b1; #1;
      n_checks++;
      if (obs !== exp_q[c]) begin
        n_fail++; $display("FAIL hs_lw cyc%0d: got %h expected %h", c + 1, obs, exp_q[c]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
`ifdef MIPS_MEM_HANDSHAKE_EN
    test_handshake();
`endif
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
